// File: rtl/instr_register_pkg.sv
// instr_register_pkg
// Shared types for the 32-entry instruction register and its readers:
// address, operand and result widths, the opcode set and the stored
// instruction record {opc, op_a, op_b, rez}.
package instr_register_pkg;

  typedef logic [4:0]          address_t;
  typedef logic signed [31:0]  operand_t;
  typedef logic signed [63:0]  rezultat;

  typedef enum logic [3:0] {
    ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD, POW
  } opcode_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    rezultat  rez;
  } instruction_t;

endpackage

// File: rtl/instr_reader_if.sv
// instr_reader_if
// Bundles every non-clock/reset signal of instr_reader:
//   run request   : start, start_addr, count
//   register port : read_pointer (to register), instruction_word (from register)
//   output stream : out_valid/out_ready handshake with out_instr, out_addr,
//                   out_mismatch
//   status        : busy, done, err_count
// master = the reader engine, slave = its environment (register + consumer).
interface instr_reader_if;
  import instr_register_pkg::*;

  logic         start;
  address_t     start_addr;
  logic [5:0]   count;

  address_t     read_pointer;
  instruction_t instruction_word;

  logic         out_valid;
  logic         out_ready;
  instruction_t out_instr;
  address_t     out_addr;
  logic         out_mismatch;

  logic         busy;
  logic         done;
  logic [5:0]   err_count;

  modport master (
    input  start, start_addr, count, instruction_word, out_ready,
    output read_pointer, out_valid, out_instr, out_addr, out_mismatch,
           busy, done, err_count
  );

  modport slave (
    output start, start_addr, count, instruction_word, out_ready,
    input  read_pointer, out_valid, out_instr, out_addr, out_mismatch,
           busy, done, err_count
  );

endinterface

// File: rtl/instr_reader.sv
// instr_reader
// Sequential read engine for the 32-entry instruction register. A start
// request walks count consecutive addresses (wrapping modulo 32) from
// start_addr, captures each word, streams it out on a valid/ready port and
// flags words whose stored rez disagrees with a recomputation from
// opc/op_a/op_b. err_count totals the flagged words of the current/last run.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : instr_reader_if.master (request, register read port, output
//             stream, status)
module instr_reader
  import instr_register_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  instr_reader_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM, S_DONE} state_t;

  state_t       r_state;
  address_t     r_read_pointer;
  logic [5:0]   r_remaining;
  logic         r_out_valid;
  instruction_t r_out_instr;
  address_t     r_out_addr;
  logic         r_out_mismatch;
  logic         r_busy;
  logic         r_done;
  logic [5:0]   r_err_count;

  logic signed [63:0] w_op_a;
  logic signed [63:0] w_op_b;
  logic signed [63:0] w_expect;
  logic               w_mismatch;
  logic [5:0]         w_run_len;
  logic               w_xfer;

  // Runs longer than the register are clamped to one full lap.
  assign w_run_len = (bus.count > 6'd32) ? 6'd32 : bus.count;
  assign w_xfer    = r_out_valid & bus.out_ready;

  // Recompute the result of the word currently addressed by read_pointer.
  assign w_op_a = {{32{bus.instruction_word.op_a[31]}}, bus.instruction_word.op_a};
  assign w_op_b = {{32{bus.instruction_word.op_b[31]}}, bus.instruction_word.op_b};

  always_comb begin
    w_expect = '0;
    case (bus.instruction_word.opc)
      ZERO:  w_expect = '0;
      PASSA: w_expect = w_op_a;
      PASSB: w_expect = w_op_b;
      ADD:   w_expect = w_op_a + w_op_b;
      SUB:   w_expect = w_op_a - w_op_b;
      MULT:  w_expect = w_op_a * w_op_b;
      DIV:   if (w_op_b != '0) w_expect = w_op_a / w_op_b;
      MOD:   if (w_op_b != '0) w_expect = w_op_a % w_op_b;
      // Zero base is forced to 0 so a negative exponent never yields x.
      POW:   if (w_op_a != '0) w_expect = w_op_a ** w_op_b;
      default: w_expect = '0;
    endcase
  end

  assign w_mismatch = (w_expect != bus.instruction_word.rez);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_read_pointer <= '0;
      r_remaining    <= '0;
      r_out_valid    <= 1'b0;
      r_out_instr    <= '0;
      r_out_addr     <= '0;
      r_out_mismatch <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err_count    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_err_count <= '0;
            if (bus.count != '0) begin
              r_read_pointer <= bus.start_addr;
              r_remaining    <= w_run_len;
              r_busy         <= 1'b1;
              r_state        <= S_FETCH;
            end else begin
              r_state <= S_DONE;
            end
          end
        end

        S_FETCH: begin
          r_out_instr    <= bus.instruction_word;
          r_out_addr     <= r_read_pointer;
          r_out_mismatch <= w_mismatch;
          r_out_valid    <= 1'b1;
          r_read_pointer <= r_read_pointer + 5'd1;
          r_state        <= S_STREAM;
        end

        S_STREAM: begin
          if (w_xfer) begin
            if (r_out_mismatch) r_err_count <= r_err_count + 6'd1;
            if (r_remaining > 6'd1) begin
              // Refill the output register on the same edge as the hand-off.
              r_out_instr    <= bus.instruction_word;
              r_out_addr     <= r_read_pointer;
              r_out_mismatch <= w_mismatch;
              r_read_pointer <= r_read_pointer + 5'd1;
              r_remaining    <= r_remaining - 6'd1;
            end else begin
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_state     <= S_DONE;
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.read_pointer = r_read_pointer;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_instr    = r_out_instr;
  assign bus.out_addr     = r_out_addr;
  assign bus.out_mismatch = r_out_mismatch;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.err_count    = r_err_count;

endmodule

// File: tb/tb_instr_reader.sv
// tb_instr_reader
// Drives runs into instr_reader from a behavioural register image and
// compares the streamed words, flags, counts and pulse timing against a
// reference model computed from the arithmetic rules of each opcode.
module tb_instr_reader;
  import instr_register_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  instr_reader_if bus();

  instr_reader dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  instruction_t mem [32];
  assign bus.instruction_word = mem[bus.read_pointer];

  int total = 0;
  int bad = 0;

  address_t     obs_addr[$];
  instruction_t obs_instr[$];
  logic         obs_mis[$];
  int           obs_unstable, obs_lag, obs_start_lag;
  bit           obs_timeout, obs_valid_seen;
  logic         obs_busy_first, obs_busy_end, obs_valid_end, obs_done_after;
  logic [5:0]   obs_err, obs_err_hold;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result from the opcode rules; POW by repeated multiplication.
  function automatic rezultat ref_result(instruction_t w);
    longint a, b, r;
    a = longint'($signed(w.op_a));
    b = longint'($signed(w.op_b));
    r = 0;
    case (w.opc)
      ZERO:  r = 0;
      PASSA: r = a;
      PASSB: r = b;
      ADD:   r = a + b;
      SUB:   r = a - b;
      MULT:  r = a * b;
      DIV:   r = (b == 0) ? 0 : a / b;
      MOD:   r = (b == 0) ? 0 : a % b;
      POW: begin
        if (a == 0) r = 0;
        else if (b < 0) begin
          if (a == 1) r = 1;
          else if (a == -1) r = ((b % 2) != 0) ? -1 : 1;
          else r = 0;
        end else begin
          r = 1;
          for (longint i = 0; i < b; i++) r = r * a;
        end
      end
      default: r = 0;
    endcase
    return rezultat'(r);
  endfunction

  function automatic instruction_t rand_word();
    instruction_t w;
    int a, b;
    if ($urandom_range(0, 7) == 0) w.opc = opcode_t'(4'($urandom_range(9, 15)));
    else w.opc = opcode_t'(4'($urandom_range(0, 8)));
    a = ($urandom_range(0, 1) == 1) ? int'($urandom) : int'($urandom_range(0, 20)) - 10;
    b = ($urandom_range(0, 1) == 1) ? int'($urandom) : int'($urandom_range(0, 20)) - 10;
    if ((w.opc == DIV || w.opc == MOD) && $urandom_range(0, 3) == 0) b = 0;
    if (w.opc == POW) b = int'($urandom_range(0, 75)) - 5;
    w.op_a = a;
    w.op_b = b;
    w.rez = '0;
    if ($urandom_range(0, 1) == 1) w.rez = ref_result(w);
    else w.rez = {$urandom(), $urandom()};
    return w;
  endfunction

  function automatic int exp_n(logic [5:0] c);
    return (c > 6'd32) ? 32 : int'(c);
  endfunction

  function automatic address_t exp_addr(address_t sa, int i);
    return address_t'((int'(sa) + i) % 32);
  endfunction

  function automatic logic exp_mis(address_t a);
    return ref_result(mem[a]) != mem[a].rez;
  endfunction

  function automatic int exp_errs(address_t sa, int n);
    int e = 0;
    for (int i = 0; i < n; i++) if (exp_mis(exp_addr(sa, i))) e++;
    return e;
  endfunction

  // Issue one run and record what comes out. mode: 0 ready high,
  // 1 random ready, 2 ready low for stall_len cycles on word stall_word.
  task automatic do_run(input address_t sa, input logic [5:0] cnt, input int mode,
                        input int stall_word, input int stall_len, input bit poke);
    int cyc, last_xfer, stall_left;
    bit xfer, held, finished;
    logic r;
    address_t h_addr;
    instruction_t h_instr;
    logic h_mis;
    obs_addr.delete(); obs_instr.delete(); obs_mis.delete();
    obs_unstable = 0; obs_lag = -1; obs_start_lag = -1;
    obs_timeout = 0; obs_valid_seen = 0;
    obs_busy_end = 1'bx; obs_valid_end = 1'bx; obs_err = 'x;
    held = 0; finished = 0; last_xfer = -1; stall_left = stall_len;
    h_addr = '0; h_instr = '0; h_mis = 1'b0;
    bus.start = 1'b1; bus.start_addr = sa; bus.count = cnt; bus.out_ready = 1'b0;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    obs_busy_first = bus.busy;
    for (int g = 0; g < 300; g++) begin
      if (bus.done === 1'b1) begin
        obs_start_lag = cyc - 1;
        if (last_xfer >= 0) obs_lag = cyc - last_xfer;
        obs_busy_end = bus.busy;
        obs_valid_end = bus.out_valid;
        obs_err = bus.err_count;
        finished = 1;
        break;
      end
      if (bus.out_valid === 1'b1) obs_valid_seen = 1;
      if (held && (bus.out_addr !== h_addr || bus.out_instr !== h_instr ||
                   bus.out_mismatch !== h_mis)) obs_unstable++;
      case (mode)
        0: r = 1'b1;
        1: r = ($urandom_range(0, 2) != 0);
        default: begin
          if (bus.out_valid === 1'b1 && obs_addr.size() == stall_word && stall_left > 0) begin
            r = 1'b0;
            stall_left--;
          end else r = 1'b1;
        end
      endcase
      bus.out_ready = r;
      bus.start = poke && (cyc == 3);
      if (poke && cyc == 3) begin
        bus.start_addr = sa + 5'd7;
        bus.count = 6'd5;
      end
      xfer = (bus.out_valid === 1'b1) && r;
      held = (bus.out_valid === 1'b1) && !r;
      h_addr = bus.out_addr; h_instr = bus.out_instr; h_mis = bus.out_mismatch;
      if (xfer) begin
        obs_addr.push_back(bus.out_addr);
        obs_instr.push_back(bus.out_instr);
        obs_mis.push_back(bus.out_mismatch);
        $display("xfer addr=%0d opc=%0d a=%0d b=%0d rez=%0d mm=%0b", bus.out_addr,
                 bus.out_instr.opc, bus.out_instr.op_a, bus.out_instr.op_b,
                 bus.out_instr.rez, bus.out_mismatch);
      end
      tick();
      cyc++;
      if (xfer) last_xfer = cyc;
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    if (!finished) obs_timeout = 1;
    tick();
    obs_done_after = bus.done;
    obs_err_hold = bus.err_count;
    $display("run sa=%0d cnt=%0d words=%0d err=%0d", sa, cnt, obs_addr.size(), obs_err);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    total++; if (bus.read_pointer !== 5'd0) begin bad++; $display("FAIL reset_rp got=%0d want=0", bus.read_pointer); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bus.out_valid); end
    total++; if (bus.out_instr !== '0) begin bad++; $display("FAIL reset_instr got=%h want=0", bus.out_instr); end
    total++; if (bus.out_addr !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", bus.out_addr); end
    total++; if (bus.out_mismatch !== 1'b0) begin bad++; $display("FAIL reset_mm got=%0b want=0", bus.out_mismatch); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", bus.done); end
    total++; if (bus.err_count !== 6'd0) begin bad++; $display("FAIL reset_err got=%0d want=0", bus.err_count); end
    reset_n = 1'b1;
    tick(); tick();
    total++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL reset_idle got=%0b%0b want=00", bus.out_valid, bus.busy); end
  endtask

  task automatic test_single();
    mem[2] = '{ADD, 32'sd5, 32'sd3, 64'sd8};
    do_run(5'd2, 6'd1, 0, 0, 0, 0);
    total++; if (obs_timeout || obs_addr.size() != 1) begin bad++; $display("FAIL single_words got=%0d want=1", obs_addr.size()); end
    if (obs_addr.size() == 1) begin
      total++; if (obs_addr[0] !== 5'd2) begin bad++; $display("FAIL single_addr got=%0d want=2", obs_addr[0]); end
      total++; if (obs_instr[0].rez !== 64'sd8) begin bad++; $display("FAIL single_rez got=%0d want=8", obs_instr[0].rez); end
      total++; if (obs_mis[0] !== 1'b0) begin bad++; $display("FAIL single_mm got=%0b want=0", obs_mis[0]); end
    end
    total++; if (obs_lag != 1) begin bad++; $display("FAIL single_done_lag got=%0d want=1", obs_lag); end
    total++; if (obs_busy_first !== 1'b1 || obs_busy_end !== 1'b0) begin bad++; $display("FAIL single_busy got=%0b%0b want=10", obs_busy_first, obs_busy_end); end
    total++; if (obs_valid_end !== 1'b0) begin bad++; $display("FAIL single_valid_end got=%0b want=0", obs_valid_end); end
    total++; if (obs_done_after !== 1'b0) begin bad++; $display("FAIL single_done_width got=%0b want=0", obs_done_after); end
    total++; if (obs_err !== 6'd0) begin bad++; $display("FAIL single_err got=%0d want=0", obs_err); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 32; i++) mem[i] = rand_word();
    do_run(5'd30, 6'd4, 0, 0, 0, 0);
    total++; if (obs_addr.size() != 4) begin bad++; $display("FAIL wrap_words got=%0d want=4", obs_addr.size()); end
    for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
      total++; if (obs_addr[i] !== exp_addr(5'd30, i)) begin bad++; $display("FAIL wrap_addr%0d got=%0d want=%0d", i, obs_addr[i], exp_addr(5'd30, i)); end
    end
    total++; if (obs_start_lag != 6) begin bad++; $display("FAIL wrap_timing got=%0d want=6", obs_start_lag); end
  endtask

  task automatic test_clamp();
    int n;
    for (int i = 0; i < 32; i++) mem[i] = rand_word();
    do_run(5'd7, 6'd40, 0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < obs_addr.size() && i < 32; i++) begin
      address_t ea;
      ea = exp_addr(5'd7, i);
      if (obs_addr[i] === ea && obs_instr[i] === mem[ea] && obs_mis[i] === exp_mis(ea)) n++;
    end
    total++; if (obs_addr.size() != 32) begin bad++; $display("FAIL clamp_words got=%0d want=32", obs_addr.size()); end
    total++; if (n != 32) begin bad++; $display("FAIL clamp_content got=%0d_ok want=32_ok", n); end
    total++; if (obs_err !== 6'(exp_errs(5'd7, 32))) begin bad++; $display("FAIL clamp_err got=%0d want=%0d", obs_err, exp_errs(5'd7, 32)); end
    total++; if (obs_start_lag != 34) begin bad++; $display("FAIL clamp_timing got=%0d want=34", obs_start_lag); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 32; i++) mem[i] = rand_word();
    do_run(5'd12, 6'd5, 2, 1, 3, 0);
    total++; if (obs_addr.size() != 5) begin bad++; $display("FAIL bp_words got=%0d want=5", obs_addr.size()); end
    for (int i = 0; i < obs_addr.size() && i < 5; i++) begin
      total++; if (obs_addr[i] !== exp_addr(5'd12, i) || obs_instr[i] !== mem[exp_addr(5'd12, i)]) begin bad++; $display("FAIL bp_word%0d got=%0d want=%0d", i, obs_addr[i], exp_addr(5'd12, i)); end
    end
    total++; if (obs_unstable != 0) begin bad++; $display("FAIL bp_stable got=%0d_changes want=0", obs_unstable); end
    total++; if (obs_start_lag != 10) begin bad++; $display("FAIL bp_timing got=%0d want=10", obs_start_lag); end
    total++; if (obs_err !== 6'(exp_errs(5'd12, 5))) begin bad++; $display("FAIL bp_err got=%0d want=%0d", obs_err, exp_errs(5'd12, 5)); end
  endtask

  task automatic test_busy_start();
    for (int i = 0; i < 32; i++) mem[i] = rand_word();
    do_run(5'd3, 6'd6, 0, 0, 0, 1);
    total++; if (obs_addr.size() != 6) begin bad++; $display("FAIL poke_words got=%0d want=6", obs_addr.size()); end
    for (int i = 0; i < obs_addr.size() && i < 6; i++) begin
      total++; if (obs_addr[i] !== exp_addr(5'd3, i)) begin bad++; $display("FAIL poke_addr%0d got=%0d want=%0d", i, obs_addr[i], exp_addr(5'd3, i)); end
    end
    total++; if (obs_err !== 6'(exp_errs(5'd3, 6))) begin bad++; $display("FAIL poke_err got=%0d want=%0d", obs_err, exp_errs(5'd3, 6)); end
  endtask

  task automatic test_mismatch();
    mem[20] = '{ADD, 32'sd5, 32'sd3, 64'sd7};
    mem[21] = '{DIV, 32'sd9, 32'sd0, 64'sd0};
    mem[22] = '{POW, 32'sd2, 32'sd10, 64'sd1024};
    do_run(5'd20, 6'd3, 1, 0, 0, 0);
    total++; if (obs_mis.size() != 3) begin bad++; $display("FAIL mm_words got=%0d want=3", obs_mis.size()); end
    if (obs_mis.size() == 3) begin
      total++; if (obs_mis[0] !== 1'b1) begin bad++; $display("FAIL mm_add got=%0b want=1", obs_mis[0]); end
      total++; if (obs_mis[1] !== 1'b0) begin bad++; $display("FAIL mm_div0 got=%0b want=0", obs_mis[1]); end
      total++; if (obs_mis[2] !== 1'b0) begin bad++; $display("FAIL mm_pow got=%0b want=0", obs_mis[2]); end
    end
    total++; if (obs_err !== 6'd1) begin bad++; $display("FAIL mm_err got=%0d want=1", obs_err); end
    total++; if (obs_err_hold !== 6'd1) begin bad++; $display("FAIL mm_err_hold got=%0d want=1", obs_err_hold); end
  endtask

  task automatic test_count0();
    do_run(5'd9, 6'd0, 0, 0, 0, 0);
    total++; if (obs_timeout || obs_start_lag != 1) begin bad++; $display("FAIL empty_done got=%0d want=1", obs_start_lag); end
    total++; if (obs_valid_seen || obs_addr.size() != 0) begin bad++; $display("FAIL empty_valid got=%0d want=0", obs_addr.size()); end
    total++; if (obs_busy_first !== 1'b0) begin bad++; $display("FAIL empty_busy got=%0b want=0", obs_busy_first); end
    total++; if (obs_err !== 6'd0) begin bad++; $display("FAIL empty_err got=%0d want=0", obs_err); end
  endtask

  task automatic test_reset_midrun();
    bit saw_done;
    bus.start = 1'b1; bus.start_addr = 5'd5; bus.count = 6'd8; bus.out_ready = 1'b0;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid got=%0b want=1", bus.out_valid); end
    reset_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL midrst_ctrl got=%0b%0b%0b want=000", bus.out_valid, bus.busy, bus.done); end
    total++; if (bus.read_pointer !== 5'd0 || bus.out_addr !== 5'd0 || bus.out_instr !== '0 || bus.out_mismatch !== 1'b0) begin bad++; $display("FAIL midrst_data got=%0d/%0d want=0/0", bus.read_pointer, bus.out_addr); end
    tick();
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    saw_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.out_valid === 1'b1 || bus.busy === 1'b1) saw_done = 1;
    end
    total++; if (saw_done) begin bad++; $display("FAIL midrst_idle got=activity want=none"); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      address_t sa;
      logic [5:0] cnt;
      int n, e;
      for (int i = 0; i < 32; i++) mem[i] = rand_word();
      sa = address_t'($urandom_range(0, 31));
      cnt = (t % 5 == 0) ? 6'($urandom_range(33, 63)) : 6'($urandom_range(0, 32));
      do_run(sa, cnt, 1, 0, 0, 0);
      n = exp_n(cnt);
      e = exp_errs(sa, n);
      total++; if (obs_timeout || obs_addr.size() != n) begin bad++; $display("FAIL rnd%0d_words got=%0d want=%0d", t, obs_addr.size(), n); end
      for (int i = 0; i < n && i < obs_addr.size(); i++) begin
        address_t ea;
        ea = exp_addr(sa, i);
        total++;
        if (obs_addr[i] !== ea || obs_instr[i] !== mem[ea] || obs_mis[i] !== exp_mis(ea)) begin
          bad++; $display("FAIL rnd%0d_word%0d got=%0d/%0b want=%0d/%0b", t, i, obs_addr[i], obs_mis[i], ea, exp_mis(ea));
        end
      end
      total++; if (obs_err !== 6'(e)) begin bad++; $display("FAIL rnd%0d_err got=%0d want=%0d", t, obs_err, e); end
      total++; if (obs_unstable != 0) begin bad++; $display("FAIL rnd%0d_stable got=%0d want=0", t, obs_unstable); end
      if (n > 0) begin
        total++; if (obs_lag != 1) begin bad++; $display("FAIL rnd%0d_done_lag got=%0d want=1", t, obs_lag); end
      end else begin
        total++; if (obs_start_lag != 1) begin bad++; $display("FAIL rnd%0d_empty got=%0d want=1", t, obs_start_lag); end
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.count = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    #2;
    test_reset();
    test_single();
    test_wrap();
    test_clamp();
    test_backpressure();
    test_busy_start();
    test_mismatch();
    test_count0();
    test_reset_midrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
